mmcm_lock_rst_seq: RTL and testbench
====================================

Name: mmcm_lock_rst_seq

Overview:
Parametrised supervisor for an MMCM clock generator. It drives the MMCM RST, watches the MMCM lock status, and retries automatically on lock timeout. Once lock is stable it releases N per-domain resets in a staggered order and re-sequences on any lock loss. It sits next to each MMCM instance in the clocking tree and runs on the free-running input clock.

Parameters:
N_CH, 5, number of sequenced output-domain resets (1..16)
SYNC_STAGES, 2, synchroniser depth on locked_in (>=2)
RST_PULSE_CYCLES, 8, mmcm_rst high time per attempt
LOCK_TIMEOUT, 65536, cycles to wait for lock before retry
LOCK_STABLE_CYCLES, 1024, cycles lock must stay high before release
STAGGER_CYCLES, 16, spacing between successive channel releases
MAX_RETRIES, 3, automatic retries before declaring fault

Ports:
clk_in1  in  1  free-running reference clock; the MMCM's CLKIN1
rst  in  1  asynchronous active-high reset
locked_in  in  1  MMCM LOCKED, asynchronous; synchronised internally
retry_req  in  1  single-cycle pulse; leaves FAULT
mmcm_rst  out  1  drives MMCM RST
ch_rst  out  N_CH  per-domain reset, active-high; bit i released i-th
ready  out  1  all channels released and lock held
fault  out  1  retries exhausted
retry_cnt  out  4  attempts consumed since last success or retry_req
loss_cnt  out  16  lock-loss event count (optional feature)

Behaviour:
- Interface: one clock, clk_in1; rst is asynchronous, active-high.
- Reset values: mmcm_rst=1, ch_rst=all 1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, synchroniser=0, state=S_MRST, timers=0.
- Outputs are registered. The sync'd lock signal is locked_s, SYNC_STAGES flops from locked_in.
- Timer width: $clog2 of the largest timing parameter plus 1. The timer clears on every state change.
- S_MRST: mmcm_rst=1 and ch_rst=all 1. After RST_PULSE_CYCLES cycles, go to S_WAIT with mmcm_rst=0.
- S_WAIT: if locked_s=1, go to S_STABLE.
  - Otherwise, when the timer reaches LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES, go to S_FAULT. Else retry_cnt+1 and go to S_MRST.
- S_STABLE: if locked_s drops, go to S_WAIT with the timer cleared and retry_cnt unchanged. If the timer reaches LOCK_STABLE_CYCLES-1, go to S_REL with idx=0.
- S_REL: every STAGGER_CYCLES cycles, clear ch_rst[idx] and increment idx. ch_rst[0] clears STAGGER_CYCLES cycles after entry. After ch_rst[N_CH-1] clears, go to S_RUN.
- S_RUN: ready=1, asserted the cycle after the last channel is released. retry_cnt clears to 0 on entry.
- Lock loss in S_REL or S_RUN (locked_s=0): on the next edge, ch_rst=all 1 and ready=0, then go to S_MRST. retry_cnt is not incremented. This counts as a loss event.
- S_FAULT: mmcm_rst=0, ch_rst=all 1, fault=1. The state holds regardless of locked_in. retry_req=1 sets fault=0 and retry_cnt=0, then goes to S_MRST. retry_req is ignored in every other state.
- Simultaneous events:
  - The lock-loss check takes priority over the stagger release in the same cycle.
  - In S_WAIT, lock arriving on the timeout cycle wins: go to S_STABLE.
- rst mid-operation: all outputs return to reset values immediately (asynchronous). Sequencing restarts from S_MRST after rst deasserts.
- Latency from a locked_in rising edge, with steady lock, to ch_rst[0] falling: SYNC_STAGES + LOCK_STABLE_CYCLES + STAGGER_CYCLES + 1 cycles.
- ch_rst is level-only. Each consumer domain adds its own reset synchroniser.

Optional Feature:
MMCM_LOCK_LOSS_CNT_EN
- Defined: loss_cnt increments on each lock-loss event in S_REL or S_RUN. It saturates at 16'hFFFF and is cleared only by rst.
- Undefined: loss_cnt is tied to 16'h0000 and no counter logic is built. The port remains present.

Test Plan:
Bench parameters for all scenarios: N_CH=3, SYNC_STAGES=2, RST_PULSE_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE_CYCLES=16, STAGGER_CYCLES=8, MAX_RETRIES=2.
1. Clean lock: rst released, locked_in rises 20 cycles after mmcm_rst falls -> ch_rst[0] falls 27 cycles later, ch_rst[1] at +35, ch_rst[2] at +43, ready=1 at +44, retry_cnt=0.
2. No lock: locked_in held at 0 -> exactly 3 mmcm_rst pulses of 4 cycles each, then fault=1, retry_cnt=2, ch_rst=3'b111. retry_req pulse -> fault=0, new 4-cycle mmcm_rst pulse.
3. Glitch during stable: locked_in high 10 cycles, low 3, high again -> no channel release until 16 consecutive sync'd-high cycles; retry_cnt unchanged.
4. Lock loss in RUN: ready=1, locked_in drops -> next edge ch_rst=3'b111 and ready=0; mmcm_rst pulses 4 cycles; loss_cnt=1 with macro defined, 0 without.
5. Async reset mid-S_REL: assert rst between ch_rst[0] and ch_rst[1] release -> ch_rst=3'b111 and mmcm_rst=1 without a clock edge; full sequence repeats after rst deasserts.

Source files
------------

// File: rtl/mmcm_lock_rst_seq.sv
// mmcm_lock_rst_seq: supervisor for one MMCM instance.
// Pulses the MMCM reset, waits for a stable lock, then releases the output
// domain resets one after another. It retries automatically when lock does not
// arrive in time, and re-sequences whenever lock is lost.
// Optional feature macro: MMCM_LOCK_LOSS_CNT_EN. When it is defined, a
// saturating lock-loss event counter drives loss_cnt. When it is undefined,
// loss_cnt is tied to zero.
module mmcm_lock_rst_seq #(
    parameter int N_CH               = 5,
    parameter int SYNC_STAGES        = 2,
    parameter int RST_PULSE_CYCLES   = 8,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 16,
    parameter int MAX_RETRIES        = 3
) (
    input  logic            clk_in1,
    input  logic            rst,
    input  logic            locked_in,
    input  logic            retry_req,
    output logic            mmcm_rst,
    output logic [N_CH-1:0] ch_rst,
    output logic            ready,
    output logic            fault,
    output logic [3:0]      retry_cnt,
    output logic [15:0]     loss_cnt
);
    localparam int MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
    localparam int T_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W = $clog2(T_MAX) + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {
        S_MRST   = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_REL    = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   locked_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TMR_W-1:0]       timer_r;
    logic [TMR_W-1:0]       timer_run_s;
    logic [TMR_W-1:0]       timer_nxt_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [N_CH-1:0]        ch_rel_s;
    logic [N_CH-1:0]        ch_rst_nxt_s;
    logic [3:0]             retry_nxt_s;
    logic                   mmcm_rst_nxt_s;
    logic                   ready_nxt_s;
    logic                   fault_nxt_s;

    // Synchronise the asynchronous MMCM LOCKED flag into clk_in1.
    always_ff @(posedge clk_in1 or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign locked_s = sync_r[SYNC_STAGES-1];

    // Compute the next state, the timer and channel bookkeeping, and the next output values.
    always_comb begin
        state_nxt_s = state_r;
        timer_run_s = timer_r + TMR_W'(1);
        idx_nxt_s   = idx_r;
        ch_rel_s    = ch_rst;
        retry_nxt_s = retry_cnt;
        case (state_r)
            S_MRST: begin
                if (timer_r == TMR_W'(RST_PULSE_CYCLES - 1)) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_MRST;
                end
            end
            S_WAIT: begin
                // Lock arriving on the timeout cycle still counts as a lock.
                if (locked_s) begin
                    state_nxt_s = S_STABLE;
                end else if (timer_r == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt == 4'(MAX_RETRIES)) begin
                        state_nxt_s = S_FAULT;
                    end else begin
                        retry_nxt_s = retry_cnt + 4'd1;
                        state_nxt_s = S_MRST;
                    end
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_nxt_s = S_WAIT;
                end else if (timer_r == TMR_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt_s = S_REL;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = S_STABLE;
                end
            end
            S_REL: begin
                // Losing lock overrides a release that falls on the same cycle.
                if (!locked_s) begin
                    state_nxt_s = S_MRST;
                end else if (timer_r == TMR_W'(STAGGER_CYCLES - 1)) begin
                    ch_rel_s[idx_r] = 1'b0;
                    timer_run_s     = {TMR_W{1'b0}};
                    if (idx_r == IDX_W'(N_CH - 1)) begin
                        state_nxt_s = S_RUN;
                        retry_nxt_s = 4'd0;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = S_REL;
                end
            end
            S_RUN: begin
                timer_run_s = {TMR_W{1'b0}};
                if (!locked_s) begin
                    state_nxt_s = S_MRST;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_FAULT: begin
                timer_run_s = {TMR_W{1'b0}};
                if (retry_req) begin
                    state_nxt_s = S_MRST;
                    retry_nxt_s = 4'd0;
                end else begin
                    state_nxt_s = S_FAULT;
                end
            end
            default: begin
                state_nxt_s = S_MRST;
                timer_run_s = {TMR_W{1'b0}};
            end
        endcase

        timer_nxt_s    = (state_nxt_s != state_r) ? {TMR_W{1'b0}} : timer_run_s;
        mmcm_rst_nxt_s = (state_nxt_s == S_MRST);
        fault_nxt_s    = (state_nxt_s == S_FAULT);
        ready_nxt_s    = (state_r == S_RUN) && (state_nxt_s == S_RUN);
        if ((state_nxt_s == S_REL) || (state_nxt_s == S_RUN)) begin
            ch_rst_nxt_s = ch_rel_s;
        end else begin
            ch_rst_nxt_s = {N_CH{1'b1}};
        end
    end

    // Hold the state, timer and channel index, and register every output.
    always_ff @(posedge clk_in1 or posedge rst) begin
        if (rst) begin
            state_r   <= S_MRST;
            timer_r   <= {TMR_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            mmcm_rst  <= 1'b1;
            ch_rst    <= {N_CH{1'b1}};
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            idx_r     <= idx_nxt_s;
            mmcm_rst  <= mmcm_rst_nxt_s;
            ch_rst    <= ch_rst_nxt_s;
            ready     <= ready_nxt_s;
            fault     <= fault_nxt_s;
            retry_cnt <= retry_nxt_s;
        end
    end

`ifdef MMCM_LOCK_LOSS_CNT_EN
    logic        loss_evt_s;
    logic [15:0] loss_cnt_r;

    assign loss_evt_s = ((state_r == S_REL) || (state_r == S_RUN)) && !locked_s;

    // Count lock-loss events after release has started, saturating at all ones.
    always_ff @(posedge clk_in1 or posedge rst) begin
        if (rst) begin
            loss_cnt_r <= 16'h0000;
        end else if (loss_evt_s && (loss_cnt_r != 16'hFFFF)) begin
            loss_cnt_r <= loss_cnt_r + 16'h0001;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`else
    assign loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mmcm_lock_rst_seq.sv
// Self-checking bench for mmcm_lock_rst_seq. Expected event times come from
// timing arithmetic: the synchroniser delay, the stability window, the stagger
// spacing and the timeout, applied to randomised lock arrival times.
module tb_mmcm_lock_rst_seq;
    localparam int N_CH = 3;
    localparam int SYNC = 2;
    localparam int RSTP = 4;
    localparam int TO   = 100;
    localparam int LS   = 16;
    localparam int ST   = 8;
    localparam int MAXR = 2;

    logic            clk_in1 = 1'b0;
    logic            rst;
    logic            locked_in;
    logic            retry_req;
    logic            mmcm_rst;
    logic [N_CH-1:0] ch_rst;
    logic            ready;
    logic            fault;
    logic [3:0]      retry_cnt;
    logic [15:0]     loss_cnt;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int exp_loss    = 0;

    mmcm_lock_rst_seq #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT(TO),
        .LOCK_STABLE_CYCLES(LS), .STAGGER_CYCLES(ST), .MAX_RETRIES(MAXR)
    ) dut (
        .clk_in1(clk_in1), .rst(rst), .locked_in(locked_in), .retry_req(retry_req),
        .mmcm_rst(mmcm_rst), .ch_rst(ch_rst), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clk_in1 = ~clk_in1;

    always @(posedge clk_in1) cyc <= cyc + 1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] exp_loss_out();
`ifdef MMCM_LOCK_LOSS_CNT_EN
        return 16'(exp_loss);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic hit(input int sel);
        case (sel)
            0: hit = (mmcm_rst === 1'b0);
            1: hit = (mmcm_rst === 1'b1);
            2: hit = (ch_rst[0] === 1'b0);
            3: hit = (ch_rst[1] === 1'b0);
            4: hit = (ch_rst[2] === 1'b0);
            5: hit = (ready === 1'b1);
            6: hit = (fault === 1'b1);
            7: hit = (ready === 1'b0);
            8: hit = (ch_rst === 3'b111);
            default: hit = 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int sel, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in1);
            if (hit(sel)) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset(output int t0);
        rst       = 1'b1;
        locked_in = 1'b0;
        retry_req = 1'b0;
        exp_loss  = 0;
        @(negedge clk_in1);
        @(negedge clk_in1);
        rst = 1'b0;
        t0  = cyc;
    endtask

    // WAIT is entered at edge tf and locked_in rises after edge tl. From these,
    // derive the expected times of each channel release and of ready.
    task automatic run_release(input int tf, input int tl, input string tag);
        int e0;
        int t;
        e0 = imax(tf + 1, tl + SYNC + 1) + LS + ST;
        wait_for(2, 300, t);
        check({tag, "_ch0_time"}, t, e0);
        check({tag, "_ch0_val"}, ch_rst, 3'b110);
        wait_for(3, 50, t);
        check({tag, "_ch1_time"}, t, e0 + ST);
        check({tag, "_ch1_val"}, ch_rst, 3'b100);
        wait_for(4, 50, t);
        check({tag, "_ch2_time"}, t, e0 + 2 * ST);
        check({tag, "_ready_early"}, ready, 1'b0);
        wait_for(5, 50, t);
        check({tag, "_ready_time"}, t, e0 + (N_CH - 1) * ST + 1);
        check({tag, "_retry_run"}, retry_cnt, 4'd0);
        check({tag, "_mmcm_run"}, mmcm_rst, 1'b0);
    endtask

    initial begin
        int   t0, tf, tl, t, d, h, g, k, j, rises, hi, e0;
        logic prev;

        rst       = 1'b1;
        locked_in = 1'b0;
        retry_req = 1'b0;
        repeat (3) @(negedge clk_in1);
        check("rst_mmcm", mmcm_rst, 1'b1);
        check("rst_ch", ch_rst, 3'b111);
        check("rst_ready", ready, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_retry", retry_cnt, 4'd0);
        check("rst_loss", loss_cnt, 16'h0000);

        // Clean lock with a randomised arrival delay. A retry_req pulse in WAIT must be ignored.
        for (int r = 0; r < 3; r++) begin
            do_reset(t0);
            wait_for(0, 50, tf);
            check("s1_mrst_width", tf - t0, RSTP);
            d = (r == 0) ? 20 : int'($urandom_range(40, 3));
            @(negedge clk_in1);
            retry_req = 1'b1;
            @(negedge clk_in1);
            retry_req = 1'b0;
            repeat (d - 2) @(negedge clk_in1);
            locked_in = 1'b1;
            tl = cyc;
            run_release(tf, tl, "s1");
        end

        // No lock: the initial attempt plus MAXR retries, then FAULT.
        do_reset(t0);
        rises = 0;
        hi    = 1;
        prev  = 1'b1;
        t     = -1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk_in1);
            if ((mmcm_rst === 1'b1) && (prev === 1'b0)) rises++;
            if (mmcm_rst === 1'b1) hi++;
            prev = mmcm_rst;
            if (fault === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("s2_fault_time", t - t0, (MAXR + 1) * (RSTP + TO));
        check("s2_retry_pulses", rises, MAXR);
        check("s2_mrst_high_total", hi, (MAXR + 1) * RSTP);
        check("s2_retry_cnt", retry_cnt, 4'(MAXR));
        check("s2_ch", ch_rst, 3'b111);
        check("s2_mmcm", mmcm_rst, 1'b0);
        k = $urandom_range(20, 5);
        for (int i = 0; i < k; i++) begin
            locked_in = 1'($urandom_range(1, 0));
            @(negedge clk_in1);
            check("s2_fault_hold", fault, 1'b1);
            check("s2_mmcm_hold", mmcm_rst, 1'b0);
        end
        locked_in = 1'b0;
        repeat (3) @(negedge clk_in1);
        retry_req = 1'b1;
        @(negedge clk_in1);
        retry_req = 1'b0;
        e0 = cyc;
        check("s2_rr_fault", fault, 1'b0);
        check("s2_rr_mmcm", mmcm_rst, 1'b1);
        check("s2_rr_retry", retry_cnt, 4'd0);
        wait_for(0, 50, tf);
        check("s2_rr_width", tf - e0, RSTP);

        // One timeout, then lock on the second attempt. retry_cnt clears on reaching RUN.
        wait_for(1, 300, t);
        check("s2b_timeout", t - tf, TO);
        check("s2b_retry1", retry_cnt, 4'd1);
        wait_for(0, 50, tf);
        check("s2b_width", tf - t, RSTP);
        d = $urandom_range(40, 3);
        repeat (d) @(negedge clk_in1);
        locked_in = 1'b1;
        tl = cyc;
        check("s2b_retry_held", retry_cnt, 4'd1);
        run_release(tf, tl, "s2b");

        // A lock glitch during the stability window restarts the window.
        do_reset(t0);
        wait_for(0, 50, tf);
        d = $urandom_range(10, 2);
        repeat (d) @(negedge clk_in1);
        locked_in = 1'b1;
        h = $urandom_range(12, 1);
        repeat (h) @(negedge clk_in1);
        locked_in = 1'b0;
        g = $urandom_range(4, 1);
        repeat (g) @(negedge clk_in1);
        locked_in = 1'b1;
        tl = cyc;
        check("s3_ch_held", ch_rst, 3'b111);
        check("s3_retry", retry_cnt, 4'd0);
        run_release(tf, tl, "s3");

        // Lock loss in RUN.
        k = $urandom_range(20, 1);
        for (int i = 0; i < k; i++) begin
            @(negedge clk_in1);
            check("s4_ready_hold", ready, 1'b1);
        end
        locked_in = 1'b0;
        tl = cyc;
        exp_loss++;
        wait_for(7, 30, t);
        check("s4_drop_time", t - tl, SYNC + 1);
        check("s4_ch", ch_rst, 3'b111);
        check("s4_mmcm", mmcm_rst, 1'b1);
        check("s4_loss", loss_cnt, exp_loss_out());
        wait_for(0, 30, tf);
        check("s4_mrst_width", tf - t, RSTP);
        check("s4_retry", retry_cnt, 4'd0);

        // Lock loss in REL that coincides with a stagger release. The loss must win.
        d = $urandom_range(30, 3);
        repeat (d) @(negedge clk_in1);
        locked_in = 1'b1;
        tl = cyc;
        e0 = imax(tf + 1, tl + SYNC + 1) + LS + ST;
        wait_for(2, 300, t);
        check("s4b_ch0_time", t, e0);
        repeat (ST - SYNC - 1) @(negedge clk_in1);
        locked_in = 1'b0;
        exp_loss++;
        wait_for(8, 30, t);
        check("s4b_collapse_time", t, e0 + ST);
        check("s4b_mmcm", mmcm_rst, 1'b1);
        check("s4b_ready", ready, 1'b0);
        check("s4b_loss", loss_cnt, exp_loss_out());

        // Asynchronous reset between the ch0 and ch1 releases, then the full sequence again.
        do_reset(t0);
        wait_for(0, 50, tf);
        d = $urandom_range(30, 3);
        repeat (d) @(negedge clk_in1);
        locked_in = 1'b1;
        tl = cyc;
        e0 = imax(tf + 1, tl + SYNC + 1) + LS + ST;
        wait_for(2, 300, t);
        check("s5_ch0_time", t, e0);
        j = $urandom_range(ST - 2, 1);
        repeat (j) @(negedge clk_in1);
        #2 rst = 1'b1;
        exp_loss = 0;
        #1;
        check("s5_async_ch", ch_rst, 3'b111);
        check("s5_async_mmcm", mmcm_rst, 1'b1);
        check("s5_async_ready", ready, 1'b0);
        check("s5_async_retry", retry_cnt, 4'd0);
        check("s5_async_loss", loss_cnt, 16'h0000);
        @(negedge clk_in1);
        rst = 1'b0;
        t0 = cyc;
        wait_for(0, 50, tf);
        check("s5_mrst_width", tf - t0, RSTP);
        run_release(tf, t0, "s5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
